lutram_fifo: RTL and testbench



---
 rtl/lutram_fifo.sv | 70 +++++++
 tb/tb_lutram_fifo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lutram_fifo.sv
// First-word-fall-through FIFO on a distributed RAM array with one write port
// and one asynchronous read port; extra pointer MSB separates full from empty.
module lutram_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 128,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     push_ready,
    output logic                     pop_valid,
    output logic [WIDTH-1:0]         pop_data,
    input  logic                     pop_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push_fire;
    logic             pop_fire;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign push_ready  = !full;
    assign pop_valid   = !empty;
    assign almost_full = (count >= AFULL_C);

    // A full FIFO refuses a push even if the head is popped in the same cycle.
    assign push_fire = push_valid && !full && !reset;
    assign pop_fire  = pop_ready && !empty && !reset;

    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (push_fire) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_lutram_fifo.sv
// Directed bench for lutram_fifo (WIDTH=8, DEPTH=4, AFULL_THRESH=2): the driver
// queues expected words as it pushes, a negedge monitor checks popped words.
module tb_lutram_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AFT   = 2;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic             push_valid = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic             push_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_ready = 1'b0;
    logic [2:0]       count;
    logic             almost_full;

    int               n_pass = 0;
    int               n_total = 0;
    int               mcnt = 0;
    logic [WIDTH-1:0] expq[$];

    lutram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
        .CLK(CLK),
        .reset(reset),
        .push_valid(push_valid),
        .push_data(push_data),
        .push_ready(push_ready),
        .pop_valid(pop_valid),
        .pop_data(pop_data),
        .pop_ready(pop_ready),
        .count(count),
        .almost_full(almost_full)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Monitor: whenever the DUT hands over a word, it must be the oldest queued one.
    always @(negedge CLK) begin
        if (!reset && pop_valid === 1'b1 && pop_ready === 1'b1) begin
            n_total++;
            if (expq.size() == 0) begin
                $display("FAIL pop_unexpected: got data 0x%0h, expected no pop", pop_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = expq.pop_front();
                if (pop_data === e) n_pass++;
                else $display("FAIL pop_data: got 0x%0h, expected 0x%0h at %0t", pop_data, e, $time);
            end
        end
    end

    // One cycle of stimulus; expected occupancy tracked independently of the DUT.
    task automatic step(input logic pv, input logic [WIDTH-1:0] pd, input logic pr, input logic rst);
        bit pf, qf;
        reset      = rst;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        pf = pv && (mcnt < DEPTH) && !rst;
        qf = pr && (mcnt > 0) && !rst;
        if (rst) begin
            expq.delete();
            mcnt = 0;
        end else begin
            if (pf) expq.push_back(pd);
            mcnt = mcnt + int'(pf) - int'(qf);
        end
        @(posedge CLK);
        #1;
        chk("count", int'(count), mcnt);
        chk("pop_valid", int'(pop_valid), int'(mcnt > 0));
        chk("push_ready", int'(push_ready), int'(mcnt < DEPTH));
        chk("almost_full", int'(almost_full), int'(mcnt >= AFT));
    endtask

    initial begin
        logic [WIDTH-1:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        // Reset then idle
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_count", int'(count), 0);

        // Fill to full, then a dropped fifth push
        for (int i = 0; i < 4; i++) begin
            step(1'b1, fill[i], 1'b0, 1'b0);
            chk("fill_count", int'(count), i + 1);
        end
        chk("full_push_ready", int'(push_ready), 0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("drop_count", int'(count), 4);

        // Drain in order
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained_count", int'(count), 0);
        chk("drained_valid", int'(pop_valid), 0);

        // Full with simultaneous push and pop: only the pop fires
        for (int i = 0; i < 4; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h70, 1'b1, 1'b0);
        chk("full_pushpop_count", int'(count), 3);
        step(1'b1, 8'h71, 1'b0, 1'b0);
        chk("refill_count", int'(count), 4);

        // Down to two entries, then 20 cycles of streaming push+pop
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("half_count", int'(count), 2);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
            chk("stream_count", int'(count), 2);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_end_count", int'(count), 0);

        // Reset discards contents and the push presented with it
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        chk("pre_reset_count", int'(count), 3);
        step(1'b1, 8'h04, 1'b0, 1'b1);
        chk("post_reset_count", int'(count), 0);
        chk("post_reset_valid", int'(pop_valid), 0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("after_reset_count", int'(count), 1);
        chk("after_reset_data", int'(pop_data), 8'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        chk("scoreboard_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
